// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: VGA scanner (fixed priority), CPU req/ack port and a screen-fill engine.
// Optional VRAM_SCROLL_EN adds a one-row scroll-up engine driven by scroll_start.
module vram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 11,
  parameter int COLS   = 40,
  parameter int DEPTH  = 1200
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              vga_rdn,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
`ifdef VRAM_SCROLL_EN
  input  logic              scroll_start,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
`ifdef VRAM_SCROLL_EN
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] SCR_LAST_A = ADDR_W'(DEPTH - COLS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    FILL
`ifdef VRAM_SCROLL_EN
    , SCR_RD,
    SCR_WR,
    SCR_FILL
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] eaddr, eaddr_nxt, eng_addr;
  logic [DATA_W-1:0] fill_word, eng_din;
  logic              eng_we, latch_fill, free, start_any, cpu_grant, in_range;
`ifdef VRAM_SCROLL_EN
  logic [DATA_W-1:0] hold;
  logic              hold_ld;
`endif

  assign vga_data = ram_dout;
  assign clr_busy = (state != IDLE);
  // Reset also blocks every write path so an aborted fill cannot land one more word.
  assign free     = vga_rdn && !rst;
  assign in_range = (cpu_addr < DEPTH_A);
`ifdef VRAM_SCROLL_EN
  assign start_any = clr_start || scroll_start;
`else
  assign start_any = clr_start;
`endif
  assign cpu_grant = free && (state == IDLE) && !start_any && cpu_req && !cpu_ack;

  always_comb begin
    state_nxt  = state;
    eaddr_nxt  = eaddr;
    eng_addr   = eaddr;
    eng_din    = fill_word;
    eng_we     = 1'b0;
    latch_fill = 1'b0;
`ifdef VRAM_SCROLL_EN
    hold_ld    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt  = FILL;
          eaddr_nxt  = '0;
          latch_fill = 1'b1;
        end
`ifdef VRAM_SCROLL_EN
        else if (scroll_start) begin
          state_nxt  = SCR_RD;
          eaddr_nxt  = '0;
          latch_fill = 1'b1;
        end
`endif
      end
      FILL: begin
        if (free) begin
          eng_we = 1'b1;
          if (eaddr == LAST_A) state_nxt = IDLE;
          else                 eaddr_nxt = eaddr + 1'b1;
        end
      end
`ifdef VRAM_SCROLL_EN
      SCR_RD: begin
        eng_addr = eaddr + COLS_A;
        if (free) begin
          hold_ld   = 1'b1;
          state_nxt = SCR_WR;
        end
      end
      SCR_WR: begin
        eng_din = hold;
        if (free) begin
          eng_we    = 1'b1;
          eaddr_nxt = eaddr + 1'b1;
          state_nxt = (eaddr == SCR_LAST_A) ? SCR_FILL : SCR_RD;
        end
      end
      SCR_FILL: begin
        if (free) begin
          eng_we = 1'b1;
          if (eaddr == LAST_A) state_nxt = IDLE;
          else                 eaddr_nxt = eaddr + 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (!vga_rdn) begin
      ram_addr = vga_addr;
    end else if (clr_busy) begin
      ram_addr = eng_addr;
      ram_din  = eng_din;
      ram_we   = eng_we;
    end else if (cpu_grant) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
      ram_we   = cpu_we && in_range;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state     <= IDLE;
      eaddr     <= '0;
      fill_word <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
`ifdef VRAM_SCROLL_EN
      hold      <= '0;
`endif
    end else begin
      state   <= state_nxt;
      eaddr   <= eaddr_nxt;
      cpu_ack <= cpu_grant;
      if (latch_fill) fill_word <= clr_data;
      if (cpu_grant && !cpu_we) cpu_rdata <= in_range ? ram_dout : '0;
`ifdef VRAM_SCROLL_EN
      if (hold_ld) hold <= ram_dout;
`endif
    end
  end

endmodule
